// File: rtl/yacht_turn_ctrl.sv
// Turn and round sequencer for Yacht Dice. Tracks per-player category
// usage, saturating totals with a one-time upper-section bonus, drives
// the dice roll trigger and picks the winner when the last round ends.
module yacht_turn_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_CATS     = 12,
  parameter int MAX_ROLLS    = 3,
  parameter int CALC_W       = 8,
  parameter int SCORE_W      = 9,
  parameter int UPPER_CATS   = 6,
  parameter int BONUS_THRESH = 63,
  parameter int BONUS_VAL    = 35
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           roll_req,
  input  logic                           sel_req,
  input  logic                           prev_req,
  input  logic                           next_req,
  input  logic [CALC_W-1:0]              calc_score,
  output logic [2:0]                     state,
  output logic [1:0]                     player_idx,
  output logic [2:0]                     roll_cnt,
  output logic                           roll_trigger,
  output logic [3:0]                     category_idx,
  output logic [3:0]                     round_num,
  output logic [NUM_CATS-1:0]            used_mask,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           game_over,
  output logic [1:0]                     winner_idx,
  output logic                           tie
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_TURN_START = 3'd1,
    S_WAIT       = 3'd2,
    S_ROLL       = 3'd3,
    S_SELECT     = 3'd4,
    S_COMMIT     = 3'd5,
    S_NEXT       = 3'd6,
    S_GAME_END   = 3'd7
  } state_t;

  // Upper sums hold up to 15 categories of full-scale calc_score without overflow.
  localparam int          UW   = CALC_W + 4;
  localparam logic [31:0] SMAX = (32'd1 << SCORE_W) - 32'd1;

  state_t                state_q;
  logic [NUM_CATS-1:0]   masks  [NUM_PLAYERS];
  logic [SCORE_W-1:0]    totals [NUM_PLAYERS];
  logic [UW-1:0]         uppers [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] bonus;

  logic [SCORE_W-1:0]    commit_total;
  logic [UW-1:0]         upper_new;
  logic                  bonus_hit;
  logic [1:0]            best_idx;
  logic                  best_tie;

  assign state     = state_q;
  assign used_mask = masks[player_idx];

  // Circular search for the next free category in either direction; stays put if none.
  function automatic logic [3:0] step_cursor(input logic [NUM_CATS-1:0] m,
                                             input logic [3:0] cur, input logic fwd);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k < NUM_CATS; k++) begin
      if (fwd) idx = (int'(cur) + k) % NUM_CATS;
      else     idx = (int'(cur) - k + NUM_CATS) % NUM_CATS;
      if (!found && !m[idx]) begin
        res   = 4'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Lowest unused category, used as the cursor at the start of each turn.
  function automatic logic [3:0] lowest_free(input logic [NUM_CATS-1:0] m);
    logic [3:0] res;
    res = 4'd0;
    for (int i = NUM_CATS - 1; i >= 0; i--) begin
      if (!m[i]) res = 4'(i);
    end
    return res;
  endfunction

  // Flatten the per-player totals onto the scores bus.
  always_comb begin
    scores = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      scores[p*SCORE_W +: SCORE_W] = totals[p];
    end
  end

  // New total, upper sum and bonus decision for the category being committed.
  always_comb begin
    logic [31:0] raw;
    logic [31:0] sat1;
    logic [31:0] with_bonus;
    raw       = 32'(totals[player_idx]) + 32'(calc_score);
    sat1      = (raw > SMAX) ? SMAX : raw;
    upper_new = uppers[player_idx];
    if (32'(category_idx) < UPPER_CATS) upper_new = upper_new + UW'(calc_score);
    bonus_hit  = !bonus[player_idx] && (32'(upper_new) >= BONUS_THRESH);
    with_bonus = sat1 + 32'(BONUS_VAL);
    if (with_bonus > SMAX) with_bonus = SMAX;
    commit_total = bonus_hit ? SCORE_W'(with_bonus) : SCORE_W'(sat1);
  end

  // Highest total wins with the lowest index taking ties; flag any shared top score.
  always_comb begin
    logic [SCORE_W-1:0] best;
    best     = totals[0];
    best_idx = 2'd0;
    best_tie = 1'b0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (totals[p] > best) begin
        best     = totals[p];
        best_idx = 2'(p);
      end
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (2'(p) != best_idx && totals[p] == best) best_tie = 1'b1;
    end
  end

  // Main sequencer: state, cursor, roll counting and score bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      player_idx   <= 2'd0;
      roll_cnt     <= 3'd0;
      roll_trigger <= 1'b0;
      category_idx <= 4'd0;
      round_num    <= 4'd1;
      game_over    <= 1'b0;
      winner_idx   <= 2'd0;
      tie          <= 1'b0;
      bonus        <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        masks[p]  <= '0;
        totals[p] <= '0;
        uppers[p] <= '0;
      end
    end else begin
      roll_trigger <= 1'b0;
      case (state_q)
        S_IDLE, S_GAME_END: begin
          if (start) begin
            state_q    <= S_TURN_START;
            player_idx <= 2'd0;
            round_num  <= 4'd1;
            roll_cnt   <= 3'd0;
            game_over  <= 1'b0;
            winner_idx <= 2'd0;
            tie        <= 1'b0;
            bonus      <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              masks[p]  <= '0;
              totals[p] <= '0;
              uppers[p] <= '0;
            end
          end
        end
        S_TURN_START: begin
          roll_cnt     <= 3'd0;
          category_idx <= lowest_free(masks[player_idx]);
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (roll_req && roll_cnt < 3'(MAX_ROLLS)) state_q <= S_ROLL;
          else if (sel_req)  state_q <= S_SELECT;
          else if (next_req) category_idx <= step_cursor(masks[player_idx], category_idx, 1'b1);
          else if (prev_req) category_idx <= step_cursor(masks[player_idx], category_idx, 1'b0);
        end
        S_ROLL: begin
          roll_cnt     <= roll_cnt + 3'd1;
          roll_trigger <= 1'b1;
          state_q      <= (roll_cnt + 3'd1 == 3'(MAX_ROLLS)) ? S_SELECT : S_WAIT;
        end
        S_SELECT: begin
          if (sel_req)       state_q <= S_COMMIT;
          else if (next_req) category_idx <= step_cursor(masks[player_idx], category_idx, 1'b1);
          else if (prev_req) category_idx <= step_cursor(masks[player_idx], category_idx, 1'b0);
        end
        S_COMMIT: begin
          totals[player_idx]               <= commit_total;
          uppers[player_idx]               <= upper_new;
          masks[player_idx][category_idx]  <= 1'b1;
          if (bonus_hit) bonus[player_idx] <= 1'b1;
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (32'(player_idx) < NUM_PLAYERS - 1) begin
            player_idx <= player_idx + 2'd1;
            state_q    <= S_TURN_START;
          end else if (32'(round_num) == NUM_CATS) begin
            game_over  <= 1'b1;
            winner_idx <= best_idx;
            tie        <= best_tie;
            state_q    <= S_GAME_END;
          end else begin
            player_idx <= 2'd0;
            round_num  <= round_num + 4'd1;
            state_q    <= S_TURN_START;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yacht_turn_ctrl.sv
// Self-checking bench for yacht_turn_ctrl with three players: a vector
// table for the opening turn, then scripted turns covering bonus,
// saturation, cursor skipping, reset mid-commit and a full tied game.
module tb_yacht_turn_ctrl;

  localparam int NP = 3;
  localparam int SW = 9;

  logic           clk;
  logic           reset_n;
  logic           start, roll_req, sel_req, prev_req, next_req;
  logic [7:0]     calc_score;
  logic [2:0]     state;
  logic [1:0]     player_idx;
  logic [2:0]     roll_cnt;
  logic           roll_trigger;
  logic [3:0]     category_idx;
  logic [3:0]     round_num;
  logic [11:0]    used_mask;
  logic [NP*SW-1:0] scores;
  logic           game_over;
  logic [1:0]     winner_idx;
  logic           tie;

  int checks   = 0;
  int failures = 0;

  int m_total [NP];
  int m_upper [NP];
  int m_bonus [NP];
  int m_player;
  int m_round;

  typedef struct {
    logic       st, roll, sel, prev, next;
    logic [7:0] calc;
    logic [2:0] e_state;
    logic [1:0] e_player;
    logic [2:0] e_cnt;
    logic       e_trig;
    logic [3:0] e_cat;
    logic [8:0] e_score0;
  } vec_t;

  vec_t vecs [17];

  yacht_turn_ctrl #(.NUM_PLAYERS(NP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .roll_req(roll_req),
    .sel_req(sel_req), .prev_req(prev_req), .next_req(next_req),
    .calc_score(calc_score), .state(state), .player_idx(player_idx),
    .roll_cnt(roll_cnt), .roll_trigger(roll_trigger), .category_idx(category_idx),
    .round_num(round_num), .used_mask(used_mask), .scores(scores),
    .game_over(game_over), .winner_idx(winner_idx), .tie(tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int score_of(input int p);
    return int'(scores[p*SW +: SW]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the rising edge.
  task automatic tick(input logic st, input logic rl, input logic sl,
                      input logic pv, input logic nx, input logic [7:0] cs);
    start = st; roll_req = rl; sel_req = sl; prev_req = pv; next_req = nx; calc_score = cs;
    @(posedge clk);
    #1;
    start = 0; roll_req = 0; sel_req = 0; prev_req = 0; next_req = 0; calc_score = 0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_total[p] = 0; m_upper[p] = 0; m_bonus[p] = 0;
    end
    m_player = 0;
    m_round  = 1;
  endtask

  task automatic model_commit(input int p, input int cat, input int calc);
    int t;
    t = m_total[p] + calc;
    if (t > 511) t = 511;
    if (cat < 6) m_upper[p] += calc;
    if (m_bonus[p] == 0 && m_upper[p] >= 63) begin
      t += 35;
      if (t > 511) t = 511;
      m_bonus[p] = 1;
    end
    m_total[p] = t;
  endtask

  // One whole turn from WAIT: steer cursor with next_req, select, commit calc.
  task automatic play_turn(input int cat, input int calc);
    bit last;
    check("turn_in_wait", int'(state), 2);
    for (int n = 0; n < 16 && int'(category_idx) != cat; n++) tick(0, 0, 0, 0, 1, 8'd0);
    check("turn_cursor_reach", int'(category_idx), cat);
    tick(0, 0, 1, 0, 0, 8'd0);
    check("turn_select", int'(state), 4);
    tick(0, 0, 1, 0, 0, 8'd0);
    check("turn_commit", int'(state), 5);
    tick(0, 0, 0, 0, 0, 8'(calc));
    check("turn_next", int'(state), 6);
    model_commit(m_player, cat, calc);
    check("turn_score", score_of(m_player), m_total[m_player]);
    last = (m_player == NP - 1) && (m_round == 12);
    tick(0, 0, 0, 0, 0, 8'd0);
    if (last) begin
      check("game_end_state", int'(state), 7);
    end else begin
      if (m_player < NP - 1) m_player++;
      else begin m_player = 0; m_round++; end
      check("turn_start_state", int'(state), 1);
      check("turn_player", int'(player_idx), m_player);
      check("turn_round", int'(round_num), m_round);
      tick(0, 0, 0, 0, 0, 8'd0);
    end
  endtask

  int p0_cats1 [7] = '{0, 1, 2, 3, 11, 4, 6};
  int p0_calc1 [7] = '{20, 20, 23, 6, 200, 196, 50};
  int p0_exp1  [7] = '{20, 40, 98, 104, 304, 500, 511};
  int p0_cats2 [12] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 5};

  initial begin
    // state, player, roll_cnt, trigger, cursor, score0
    vecs[0]  = '{1,0,0,0,0, 8'd0,  3'd1, 2'd0, 3'd0, 1'b0, 4'd0,  9'd0};
    vecs[1]  = '{0,0,0,0,0, 8'd0,  3'd2, 2'd0, 3'd0, 1'b0, 4'd0,  9'd0};
    vecs[2]  = '{0,1,0,0,0, 8'd0,  3'd3, 2'd0, 3'd0, 1'b0, 4'd0,  9'd0};
    vecs[3]  = '{0,1,0,0,0, 8'd0,  3'd2, 2'd0, 3'd1, 1'b1, 4'd0,  9'd0};
    vecs[4]  = '{0,1,0,0,0, 8'd0,  3'd3, 2'd0, 3'd1, 1'b0, 4'd0,  9'd0};
    vecs[5]  = '{0,0,0,0,0, 8'd0,  3'd2, 2'd0, 3'd2, 1'b1, 4'd0,  9'd0};
    vecs[6]  = '{0,1,0,0,0, 8'd0,  3'd3, 2'd0, 3'd2, 1'b0, 4'd0,  9'd0};
    vecs[7]  = '{0,1,0,0,0, 8'd0,  3'd4, 2'd0, 3'd3, 1'b1, 4'd0,  9'd0};
    vecs[8]  = '{1,1,0,0,0, 8'd0,  3'd4, 2'd0, 3'd3, 1'b0, 4'd0,  9'd0};
    vecs[9]  = '{0,0,0,0,1, 8'd0,  3'd4, 2'd0, 3'd3, 1'b0, 4'd1,  9'd0};
    vecs[10] = '{0,0,0,1,0, 8'd0,  3'd4, 2'd0, 3'd3, 1'b0, 4'd0,  9'd0};
    vecs[11] = '{0,0,0,1,0, 8'd0,  3'd4, 2'd0, 3'd3, 1'b0, 4'd11, 9'd0};
    vecs[12] = '{0,0,0,1,1, 8'd0,  3'd4, 2'd0, 3'd3, 1'b0, 4'd0,  9'd0};
    vecs[13] = '{0,0,1,0,0, 8'd0,  3'd5, 2'd0, 3'd3, 1'b0, 4'd0,  9'd0};
    vecs[14] = '{0,0,0,0,0, 8'd20, 3'd6, 2'd0, 3'd3, 1'b0, 4'd0,  9'd20};
    vecs[15] = '{0,0,0,0,0, 8'd0,  3'd1, 2'd1, 3'd3, 1'b0, 4'd0,  9'd20};
    vecs[16] = '{0,0,0,0,0, 8'd0,  3'd2, 2'd1, 3'd0, 1'b0, 4'd0,  9'd20};

    start = 0; roll_req = 0; sel_req = 0; prev_req = 0; next_req = 0; calc_score = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1;
    @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_round", int'(round_num), 1);
    check("rst_game_over", int'(game_over), 0);
    check("rst_scores", int'(scores), 0);

    // Opening turn: roll limit, dropped pulses, cursor wrap, first commit.
    for (int i = 0; i < 17; i++) begin
      tick(vecs[i].st, vecs[i].roll, vecs[i].sel, vecs[i].prev, vecs[i].next, vecs[i].calc);
      check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].e_state));
      check($sformatf("vec%0d_player", i), int'(player_idx), int'(vecs[i].e_player));
      check($sformatf("vec%0d_roll_cnt", i), int'(roll_cnt), int'(vecs[i].e_cnt));
      check($sformatf("vec%0d_trigger", i), int'(roll_trigger), int'(vecs[i].e_trig));
      check($sformatf("vec%0d_cursor", i), int'(category_idx), int'(vecs[i].e_cat));
      check($sformatf("vec%0d_score0", i), score_of(0), int'(vecs[i].e_score0));
    end

    model_reset();
    model_commit(0, 0, 20);
    m_player = 1;
    play_turn(0, 0);
    play_turn(0, 0);

    // Rounds 2..7: bonus, no re-award, cursor skip, saturation.
    for (int r = 2; r <= 7; r++) begin
      if (r == 6) begin
        check("skip_mask", int'(used_mask), 12'h80F);
        check("skip_cursor", int'(category_idx), 4);
        tick(0, 0, 0, 1, 0, 8'd0);
        check("skip_prev", int'(category_idx), 10);
        tick(0, 0, 0, 0, 1, 8'd0);
        check("skip_next", int'(category_idx), 4);
      end
      play_turn(p0_cats1[r-1], p0_calc1[r-1]);
      check($sformatf("p0_total_r%0d", r), score_of(0), p0_exp1[r-1]);
      play_turn(r - 1, 0);
      play_turn(r - 1, 0);
    end

    // Reset while in COMMIT: no partial commit, immediate return to IDLE.
    tick(0, 0, 1, 0, 0, 8'd0);
    tick(0, 0, 1, 0, 0, 8'd0);
    check("pre_reset_commit", int'(state), 5);
    calc_score = 8'd100;
    reset_n = 0;
    #2;
    check("midrst_state", int'(state), 0);
    check("midrst_scores", int'(scores), 0);
    check("midrst_mask", int'(used_mask), 0);
    check("midrst_round", int'(round_num), 1);
    reset_n = 1;
    calc_score = 8'd0;
    tick(1, 0, 0, 0, 0, 8'd0);
    check("restart_state", int'(state), 1);
    check("restart_round", int'(round_num), 1);
    tick(0, 0, 0, 0, 0, 8'd0);
    check("restart_wait", int'(state), 2);
    check("restart_cursor", int'(category_idx), 0);

    // Full game: P1 and P2 tie at the top.
    model_reset();
    for (int r = 1; r <= 12; r++) begin
      if (r == 12) begin
        check("one_free_mask", int'(used_mask), 12'hFDF);
        check("one_free_cursor", int'(category_idx), 5);
        tick(0, 0, 0, 0, 1, 8'd0);
        check("one_free_next", int'(category_idx), 5);
        tick(0, 0, 0, 1, 0, 8'd0);
        check("one_free_prev", int'(category_idx), 5);
      end
      play_turn(p0_cats2[r-1], 1);
      play_turn(r - 1, 2);
      play_turn(r - 1, 2);
    end
    check("end_round", int'(round_num), 12);
    check("end_game_over", int'(game_over), 1);
    check("end_winner", int'(winner_idx), 1);
    check("end_tie", int'(tie), 1);
    check("end_score0", score_of(0), 12);
    check("end_score1", score_of(1), 24);
    check("end_score2", score_of(2), 24);
    tick(0, 1, 1, 0, 0, 8'd0);
    check("end_hold_state", int'(state), 7);
    check("end_hold_winner", int'(winner_idx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
